// File: rtl/lag_timer.sv
// Flash-to-light latency timer: synchronizes and debounces a light sensor, measures the delay
// from a start pulse to the debounced edge, and keeps min/max/block-average statistics.
module lag_timer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 16,
  parameter logic [23:0] TIMEOUT     = 24'd4_000_000,
  parameter bit          ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  input  logic        sensor,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic        stuck,
  output logic [23:0] lag,
  output logic [23:0] lag_min,
  output logic [23:0] lag_max,
  output logic [23:0] lag_avg,
  output logic        avg_valid,
  output logic [3:0]  sample_cnt
);

  localparam int unsigned DbW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [24:0] Offset = 25'(SYNC_STAGES + DEBOUNCE);

  typedef enum logic [1:0] {StIdle, StMeasure, StPublish} state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lit_s;
  logic                   db_q, db_d;
  logic [DbW-1:0]         db_cnt_q, db_cnt_d;
  state_e                 state_q, state_d;
  logic [23:0]            cnt_q, cnt_d;
  logic [23:0]            lag_q, lag_d;
  logic                   to_q, to_d;
  logic                   stuck_q, stuck_d;
  logic [23:0]            min_q, min_d, max_q, max_d, avg_q, avg_d;
  logic                   avgv_q, avgv_d;
  logic [27:0]            acc_q, acc_d;
  logic [3:0]             scnt_q, scnt_d;
  logic [24:0]            elapsed;
  logic [27:0]            acc_sum;

  always_comb begin
    sync_d[0] = sensor;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign lit_s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (lit_s != db_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE - 1)) begin
        db_d = lit_s;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // The rise is seen one cycle after the counter sampled it, hence the +1 before removing
  // the fixed synchronizer/debounce delay.
  assign elapsed = {1'b0, cnt_q} + 25'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lag_d   = lag_q;
    to_d    = to_q;
    stuck_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (db_q) begin
            stuck_d = 1'b1;
          end else begin
            state_d = StMeasure;
            cnt_d   = '0;
          end
        end
      end
      StMeasure: begin
        if (db_q) begin
          state_d = StPublish;
          to_d    = 1'b0;
          lag_d   = (elapsed > Offset) ? 24'(elapsed - Offset) : '0;
        end else if (cnt_q >= TIMEOUT) begin
          state_d = StPublish;
          to_d    = 1'b1;
          lag_d   = TIMEOUT;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      StPublish: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign acc_sum = acc_q + {4'b0, lag_q};

  // Clear outranks a coinciding publish so the sample never lands in fresh statistics.
  always_comb begin
    min_d  = min_q;
    max_d  = max_q;
    avg_d  = avg_q;
    avgv_d = avgv_q;
    acc_d  = acc_q;
    scnt_d = scnt_q;
    if (clear) begin
      min_d  = 24'hFFFFFF;
      max_d  = '0;
      acc_d  = '0;
      scnt_d = '0;
      avgv_d = 1'b0;
    end else if (state_q == StPublish && !to_q) begin
      if (lag_q < min_q) min_d = lag_q;
      if (lag_q > max_q) max_d = lag_q;
      if (scnt_q == 4'd15) begin
        avg_d  = acc_sum[27:4];
        avgv_d = 1'b1;
        acc_d  = '0;
        scnt_d = '0;
      end else begin
        acc_d  = acc_sum;
        scnt_d = scnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{ACTIVE_LOW}};
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      state_q  <= StIdle;
      cnt_q    <= '0;
      lag_q    <= '0;
      to_q     <= 1'b0;
      stuck_q  <= 1'b0;
      min_q    <= 24'hFFFFFF;
      max_q    <= '0;
      avg_q    <= '0;
      avgv_q   <= 1'b0;
      acc_q    <= '0;
      scnt_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lag_q    <= lag_d;
      to_q     <= to_d;
      stuck_q  <= stuck_d;
      min_q    <= min_d;
      max_q    <= max_d;
      avg_q    <= avg_d;
      avgv_q   <= avgv_d;
      acc_q    <= acc_d;
      scnt_q   <= scnt_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StPublish);
  assign timed_out  = to_q;
  assign stuck      = stuck_q;
  assign lag        = lag_q;
  assign lag_min    = min_q;
  assign lag_max    = max_q;
  assign lag_avg    = avg_q;
  assign avg_valid  = avgv_q;
  assign sample_cnt = scnt_q;

endmodule

// File: tb/tb_lag_timer.sv
// Bench for lag_timer: directed scenarios plus randomized measurements, checked every cycle
// against a sample-list statistics model and the lag = N rule.
module tb_lag_timer;

  localparam int unsigned S  = 2;
  localparam int unsigned D  = 16;
  localparam int          T  = 2500;
  localparam bit          AL = 1'b1;

  logic        clk = 1'b0;
  logic        reset, start, clear, sensor;
  logic        busy, done, timed_out, stuck, avg_valid;
  logic [23:0] lag, lag_min, lag_max, lag_avg;
  logic [3:0]  sample_cnt;

  always #5 clk = ~clk;

  lag_timer #(
    .SYNC_STAGES(S),
    .DEBOUNCE   (D),
    .TIMEOUT    (24'(T)),
    .ACTIVE_LOW (AL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .clear     (clear),
    .sensor    (sensor),
    .busy      (busy),
    .done      (done),
    .timed_out (timed_out),
    .stuck     (stuck),
    .lag       (lag),
    .lag_min   (lag_min),
    .lag_max   (lag_max),
    .lag_avg   (lag_avg),
    .avg_valid (avg_valid),
    .sample_cnt(sample_cnt)
  );

  // Edge bookkeeping: at a negedge, edge_n is the index of the edge just taken and the
  // *_seen flags are the inputs sampled at it.
  int edge_n     = 0;
  bit m_rst_seen = 1'b0;
  bit m_clr_seen = 1'b0;
  always @(posedge clk) begin
    edge_n     <= edge_n + 1;
    m_rst_seen <= reset;
    m_clr_seen <= clear;
  end

  // Expectations posted by the stimulus process.
  bit    m_active   = 1'b0;
  int    m_start    = 0;
  int    m_done_e   = 0;
  int    m_abort    = 0;
  int    m_stuck_e  = -1;
  int    m_lag_exp  = 0;
  bit    m_to_exp   = 1'b0;
  bit    pin_en     = 1'b0;
  string pin_name;
  int    pin_lag, pin_min, pin_max, pin_cnt, pin_avg, pin_avgv;

  // Model and score owned by the compare process.
  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;
  int m_lag_hold = 0;
  bit pend = 1'b0;
  int pend_lag = 0;
  int samp[$];
  int blk[$];
  int m_avg = 0;
  bit m_avgv = 1'b0;

  function automatic void chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at edge %0d", nm, act, exp, edge_n);
    end
  endfunction

  function automatic void add_sample(input int v);
    int sum;
    samp.push_back(v);
    blk.push_back(v);
    if (blk.size() == 16) begin
      sum = 0;
      foreach (blk[i]) sum += blk[i];
      m_avg  = sum / 16;
      m_avgv = 1'b1;
      blk.delete();
    end
  endfunction

  always @(negedge clk) begin
    int k, e_min, e_max;
    bit live, e_busy, e_done, e_stuck;
    k = edge_n;
    if (m_rst_seen) begin
      started    = 1'b1;
      m_lag_hold = 0;
      pend       = 1'b0;
      samp.delete();
      blk.delete();
      m_avg      = 0;
      m_avgv     = 1'b0;
    end else begin
      if (m_clr_seen) begin
        samp.delete();
        blk.delete();
        m_avgv = 1'b0;
      end else if (pend) begin
        add_sample(pend_lag);
      end
      pend = 1'b0;
    end
    if (started) begin
      live    = m_active && k >= m_start && k < m_abort;
      e_busy  = live && k <= m_done_e;
      e_done  = live && k == m_done_e;
      e_stuck = (k == m_stuck_e);
      if (e_done) begin
        m_lag_hold = m_lag_exp;
        if (!m_to_exp) begin
          pend     = 1'b1;
          pend_lag = m_lag_exp;
        end
      end
      e_min = 24'hFFFFFF;
      e_max = 0;
      foreach (samp[i]) begin
        if (samp[i] < e_min) e_min = samp[i];
        if (samp[i] > e_max) e_max = samp[i];
      end
      chk("busy", busy, e_busy);
      chk("done", done, e_done);
      chk("stuck", stuck, e_stuck);
      chk("lag", lag, m_lag_hold);
      if (e_done) chk("timed_out", timed_out, m_to_exp);
      chk("lag_min", lag_min, e_min);
      chk("lag_max", lag_max, e_max);
      chk("sample_cnt", sample_cnt, blk.size());
      chk("lag_avg", lag_avg, m_avg);
      chk("avg_valid", avg_valid, m_avgv);
      if (pin_en) begin
        chk({pin_name, "_lag"}, lag, pin_lag);
        chk({pin_name, "_min"}, lag_min, pin_min);
        chk({pin_name, "_max"}, lag_max, pin_max);
        chk({pin_name, "_cnt"}, sample_cnt, pin_cnt);
        chk({pin_name, "_avg"}, lag_avg, pin_avg);
        chk({pin_name, "_avgv"}, avg_valid, pin_avgv);
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pin(input string nm, input int l, input int mn, input int mx, input int c,
                     input int a, input int av);
    pin_name = nm;
    pin_lag  = l;
    pin_min  = mn;
    pin_max  = mx;
    pin_cnt  = c;
    pin_avg  = a;
    pin_avgv = av;
    pin_en   = 1'b1;
    @(negedge clk);
    #1;
    pin_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Relative edge after which done is expected: raw edge sampled N edges after start,
  // plus the synchronizer and debounce delay, or the timeout bound.
  function automatic int rel_of(input int n, input bit never);
    if (!never && n + int'(S + D) <= T + 1) return n + int'(S + D);
    return T + 1;
  endfunction

  // Offsets are in edges after the start edge; -1 disables an event.
  task automatic run_meas(input int n, input bit never, input int goff, input int glen,
                          input int xoff, input int coff, input int roff);
    int s, rel;
    bit lit;
    s         = edge_n + 1;
    rel       = rel_of(n, never);
    m_start   = s;
    m_done_e  = s + rel;
    m_abort   = 32'h7fff_ffff;
    m_to_exp  = never || (n + int'(S + D) > T + 1);
    m_lag_exp = m_to_exp ? T : n;
    m_active  = 1'b1;
    for (int j = 0; j <= rel + 1; j++) begin
      start  = (j == 0) || (j == xoff);
      lit    = (!never && j >= n) || (glen > 0 && j >= goff && j < goff + glen);
      sensor = lit ^ AL;
      clear  = (j == coff);
      reset  = (j == roff);
      if (j == roff) m_abort = s + j;
      tick(1);
      if (j == roff) break;
    end
    start  = 1'b0;
    clear  = 1'b0;
    reset  = 1'b0;
    sensor = AL;
    tick(S + D + 4);
  endtask

  task automatic stuck_test();
    sensor = ~AL;
    tick(S + D + 4);
    start     = 1'b1;
    m_stuck_e = edge_n + 1;
    tick(1);
    start = 1'b0;
    tick(3);
    sensor = AL;
    tick(S + D + 4);
  endtask

  initial begin
    int n, rel, goff, glen, xoff, coff, roff;
    bit never;
    reset  = 1'b1;
    start  = 1'b0;
    clear  = 1'b0;
    sensor = AL;
    tick(3);
    reset = 1'b0;
    tick(2);
    pin("reset", 0, 24'hFFFFFF, 0, 0, 0, 0);

    run_meas(1000, 1'b0, -1, 0, -1, -1, -1);
    pin("basic", 1000, 1000, 1000, 1, 0, 0);
    run_meas(2000, 1'b0, 300, 5, -1, -1, -1);
    pin("glitch", 2000, 1000, 2000, 2, 0, 0);
    run_meas(0, 1'b1, -1, 0, -1, -1, -1);
    pin("timeout", T, 1000, 2000, 2, 0, 0);
    stuck_test();
    run_meas(400, 1'b0, -1, 0, 100, -1, -1);
    pin("restart", 400, 400, 2000, 3, 0, 0);
    run_meas(0, 1'b1, -1, 0, -1, -1, 200);
    pin("abort", 0, 24'hFFFFFF, 0, 0, 0, 0);
    run_meas(500, 1'b0, -1, 0, -1, -1, -1);
    pin("after_rst", 500, 500, 500, 1, 0, 0);
    run_meas(300, 1'b0, -1, 0, -1, 300 + int'(S + D) + 1, -1);
    pin("clr_pub", 300, 24'hFFFFFF, 0, 0, 0, 0);

    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(1);
    for (int i = 0; i < 16; i++) run_meas(100 + i, 1'b0, -1, 0, -1, -1, -1);
    pin("avg", 115, 100, 115, 0, 107, 1);

    for (int it = 0; it < 24; it++) begin
      n     = $urandom_range(0, 700);
      never = ($urandom_range(0, 9) == 0);
      rel   = rel_of(n, never);
      goff  = -1;
      glen  = 0;
      xoff  = -1;
      coff  = -1;
      roff  = -1;
      if ($urandom_range(0, 1) == 1 && (never || n >= 30)) begin
        glen = $urandom_range(1, D - 1);
        goff = never ? $urandom_range(1, 600) : $urandom_range(1, n - glen - 2);
      end
      if ($urandom_range(0, 2) == 0) xoff = $urandom_range(1, rel + 1);
      if ($urandom_range(0, 3) == 0) coff = $urandom_range(0, rel + 1);
      if ($urandom_range(0, 11) == 0) roff = $urandom_range(0, rel);
      run_meas(n, never, goff, glen, xoff, coff, roff);
      if ($urandom_range(0, 9) == 0) stuck_test();
    end

    tick(5);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
